// File: rtl/digit_strip_display.sv
// digit_strip_display
//   Renders a binary value as a strip of NUM_DIGITS decimal digits with an
//   optional ":" slot, for the digit bitmap ROM. The value is converted to BCD
//   on-chip with a serial double-dabble converter started once per frame. The
//   on-screen number only changes when a conversion completes.
//
// Ports
//   clk, resetN            : clock, asynchronous active-low reset
//   startOfFrame           : one-cycle pulse per VGA frame (starts conversion, steps blink)
//   pixelX, pixelY         : current VGA pixel
//   topLeftX, topLeftY     : signed strip origin
//   value                  : binary number to display
//   blankLeading           : show leading zeros as blank
//   blinkEn                : enable frame-based blinking
//   offsetX, offsetY       : pixel offset inside the current slot (registered)
//   drawingRequest         : pixel lies inside a visible slot (registered)
//   current_digit          : 0..9 digit, 4'hA ":", 4'hF blank (registered)
//   convBusy               : BCD conversion in progress
module digit_strip_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int VALUE_W      = 14,
  parameter int SEP_AFTER    = 2,
  parameter int DIGIT_W      = 16,
  parameter int DIGIT_H      = 32,
  parameter int BLINK_FRAMES = 15
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic [10:0]         pixelX,
  input  logic [10:0]         pixelY,
  input  logic signed [10:0]  topLeftX,
  input  logic signed [10:0]  topLeftY,
  input  logic [VALUE_W-1:0]  value,
  input  logic                blankLeading,
  input  logic                blinkEn,
  output logic [10:0]         offsetX,
  output logic [10:0]         offsetY,
  output logic                drawingRequest,
  output logic [3:0]          current_digit,
  output logic                convBusy
);

  localparam int SLOTS   = NUM_DIGITS + ((SEP_AFTER > 0) ? 1 : 0);
  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int SHIFT_X = $clog2(DIGIT_W);
  localparam int CNT_W   = $clog2(VALUE_W + 1);
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic signed [11:0] STRIP_W  = 12'(SLOTS * DIGIT_W);
  localparam logic signed [11:0] STRIP_H  = 12'(DIGIT_H);
  localparam logic [10:0]        OFS_MASK = 11'(DIGIT_W - 1);

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_m1(NUM_DIGITS);

  // Clamp to the largest number the strip can show.
  function automatic logic [VALUE_W-1:0] sat_value(input logic [VALUE_W-1:0] v);
    if (64'(v) > MAX_VAL) return MAX_VAL[VALUE_W-1:0];
    return v;
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic               start_conv, done_conv;
  logic [CNT_W-1:0]   step_cnt;
  logic [VALUE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   acc, acc_adj, acc_nxt;
  logic [BCD_W-1:0]   disp_bcd;
  logic [FRM_W-1:0]   frame_cnt;
  logic               phase_on;

  assign acc_adj  = dabble(acc);
  assign acc_nxt  = {acc_adj[BCD_W-2:0], bin_sr[VALUE_W-1]};
  assign convBusy = (state == SHIFT);

  always_comb begin
    state_nxt  = state;
    start_conv = 1'b0;
    done_conv  = 1'b0;
    case (state)
      IDLE: if (startOfFrame) begin
        state_nxt  = SHIFT;
        start_conv = 1'b1;
      end
      SHIFT: if (step_cnt == CNT_W'(VALUE_W - 1)) begin
        state_nxt = IDLE;
        done_conv = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      step_cnt <= '0;
      disp_bcd <= '0;
    end else begin
      state <= state_nxt;
      if (start_conv)          step_cnt <= '0;
      else if (state == SHIFT) step_cnt <= step_cnt + 1'b1;
      if (done_conv)           disp_bcd <= acc_nxt;
    end
  end

  // Converter datapath: contents are meaningless outside SHIFT.
  always_ff @(posedge clk) begin
    if (start_conv) begin
      bin_sr <= sat_value(value);
      acc    <= '0;
    end else if (state == SHIFT) begin
      bin_sr <= bin_sr << 1;
      acc    <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (startOfFrame) begin
      if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---- stage p0: pixel geometry and slot code (combinational) ----
  logic signed [11:0]   relx_p0, rely_p0;
  logic [11:0]          relx_u_p0, slot_p0;
  logic                 inside_p0;
  logic [BCD_W-1:0]     src_bcd_p0;
  logic [4*NUM_DIGITS-1:0] dcode_p0;
  logic [4*SLOTS-1:0]   scode_p0;
  logic [3:0]           code_p0;
  logic                 lead_p0;
  logic [3:0]           d_p0;
  int                   idx_p0;

  assign relx_p0   = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign rely_p0   = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});
  assign relx_u_p0 = relx_p0;
  assign slot_p0   = relx_u_p0 >> SHIFT_X;
  assign inside_p0 = (relx_p0 >= 12'sd0) && (relx_p0 < STRIP_W) &&
                     (rely_p0 >= 12'sd0) && (rely_p0 < STRIP_H);

  // Finishing conversion is forwarded so the pixel sampled on the completion
  // edge already sees the new number.
  assign src_bcd_p0 = done_conv ? acc_nxt : disp_bcd;

  always_comb begin
    dcode_p0 = '0;
    scode_p0 = '0;
    code_p0  = 4'hF;
    lead_p0  = blankLeading;
    d_p0     = 4'h0;
    idx_p0   = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d_p0 = src_bcd_p0[4*(NUM_DIGITS-1-i) +: 4];
      if (lead_p0 && (d_p0 == 4'h0) && (i != NUM_DIGITS - 1))
        dcode_p0[4*i +: 4] = 4'hF;
      else
        dcode_p0[4*i +: 4] = d_p0;
      if (d_p0 != 4'h0) lead_p0 = 1'b0;
    end
    for (int s = 0; s < SLOTS; s++) begin
      if ((SEP_AFTER > 0) && (s == SEP_AFTER)) begin
        scode_p0[4*s +: 4] = 4'hA;
      end else begin
        idx_p0 = ((SEP_AFTER > 0) && (s > SEP_AFTER)) ? s - 1 : s;
        scode_p0[4*s +: 4] = dcode_p0[4*idx_p0 +: 4];
      end
    end
    for (int s = 0; s < SLOTS; s++)
      if (slot_p0 == 12'(s)) code_p0 = scode_p0[4*s +: 4];
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      current_digit  <= 4'hF;
      offsetX        <= '0;
      offsetY        <= '0;
    end else if (inside_p0) begin
      drawingRequest <= !(blinkEn && !phase_on);
      current_digit  <= code_p0;
      offsetX        <= relx_u_p0[10:0] & OFS_MASK;
      offsetY        <= rely_p0[10:0];
    end else begin
      drawingRequest <= 1'b0;
      current_digit  <= 4'hF;
      offsetX        <= '0;
      offsetY        <= '0;
    end
  end

endmodule

// File: tb/tb_digit_strip_display.sv
// tb_digit_strip_display
//   Directed bench for digit_strip_display: default instance for mapping,
//   conversion, blanking and reset; a BLINK_FRAMES=2 instance for blinking.
module tb_digit_strip_display;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic [10:0]        pixelX, pixelY;
  logic signed [10:0] topLeftX, topLeftY;
  logic [13:0]        value;
  logic               blankLeading, blinkEn;

  logic [10:0] offsetX, offsetY, b_offsetX, b_offsetY;
  logic        drawingRequest, convBusy, b_drawingRequest, b_convBusy;
  logic [3:0]  current_digit, b_current_digit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  digit_strip_display dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .value(value), .blankLeading(blankLeading), .blinkEn(blinkEn),
    .offsetX(offsetX), .offsetY(offsetY), .drawingRequest(drawingRequest),
    .current_digit(current_digit), .convBusy(convBusy)
  );

  digit_strip_display #(.BLINK_FRAMES(2)) dutb (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .value(value), .blankLeading(blankLeading), .blinkEn(blinkEn),
    .offsetX(b_offsetX), .offsetY(b_offsetY), .drawingRequest(b_drawingRequest),
    .current_digit(b_current_digit), .convBusy(b_convBusy)
  );

  typedef struct {
    logic [10:0] x, y;
    logic        dr;
    logic [3:0]  dig;
    logic [10:0] ox, oy;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
  endtask

  // Runs one conversion and waits (bounded) for it to finish.
  task automatic convert(input logic [13:0] v);
    int n;
    value = v;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    n = 0;
    while (convBusy && n < 100) begin
      tick();
      n++;
    end
    check("conv_done", convBusy, 1'b0);
  endtask

  // Expected slot codes packed MSB-first: slot0 in bits 19:16.
  task automatic check_strip(input string name, input logic [19:0] exp);
    for (int s = 0; s < 5; s++) begin
      pix(100 + 16 * s, 50);
      check($sformatf("%s_slot%0d", name, s), current_digit, exp[4*(4-s) +: 4]);
    end
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    resetN = 1'b0; startOfFrame = 1'b0;
    pixelX = 11'd100; pixelY = 11'd50;
    topLeftX = 11'sd100; topLeftY = 11'sd50;
    value = 14'd1234; blankLeading = 1'b0; blinkEn = 1'b0;

    vecs[0] = '{11'd100, 11'd50, 1'b1, 4'h1, 11'd0,  11'd0};
    vecs[1] = '{11'd116, 11'd50, 1'b1, 4'h2, 11'd0,  11'd0};
    vecs[2] = '{11'd132, 11'd60, 1'b1, 4'hA, 11'd0,  11'd10};
    vecs[3] = '{11'd155, 11'd55, 1'b1, 4'h3, 11'd7,  11'd5};
    vecs[4] = '{11'd179, 11'd81, 1'b1, 4'h4, 11'd15, 11'd31};
    vecs[5] = '{11'd180, 11'd50, 1'b0, 4'hF, 11'd0,  11'd0};
    vecs[6] = '{11'd99,  11'd50, 1'b0, 4'hF, 11'd0,  11'd0};
    vecs[7] = '{11'd100, 11'd82, 1'b0, 4'hF, 11'd0,  11'd0};
    vecs[8] = '{11'd100, 11'd49, 1'b0, 4'hF, 11'd0,  11'd0};

    #12;
    check("rst_dr",    drawingRequest, 1'b0);
    check("rst_digit", current_digit,  4'hF);
    check("rst_ox",    offsetX,        11'd0);
    check("rst_oy",    offsetY,        11'd0);
    check("rst_busy",  convBusy,       1'b0);
    resetN = 1'b1;

    // Blink with BLINK_FRAMES=2 on a strip pixel.
    blinkEn = 1'b1;
    tick();
    check("blink_f0", b_drawingRequest, 1'b1);
    pulse_sof(); tick(); check("blink_f1", b_drawingRequest, 1'b1);
    pulse_sof(); tick(); check("blink_f2", b_drawingRequest, 1'b0);
    check("blink_f2_default_inst", drawingRequest, 1'b1);
    check("blink_f2_ox_kept", b_offsetX, 11'd0);
    check("blink_f2_digit", b_current_digit, 4'h0);
    pulse_sof(); tick(); check("blink_f3", b_drawingRequest, 1'b0);
    pulse_sof(); tick(); check("blink_f4", b_drawingRequest, 1'b1);
    pulse_sof(); tick(); check("blink_f5", b_drawingRequest, 1'b1);
    pulse_sof(); tick(); check("blink_f6", b_drawingRequest, 1'b0);
    blinkEn = 1'b0;
    tick();
    check("blink_clear", b_drawingRequest, 1'b1);

    resetN = 1'b0;
    #3;
    resetN = 1'b1;
    tick();

    // Mapping table.
    convert(14'd1234);
    for (int i = 0; i < 9; i++) begin
      pix(vecs[i].x, vecs[i].y);
      check($sformatf("map%0d_dr", i),  drawingRequest, vecs[i].dr);
      check($sformatf("map%0d_dig", i), current_digit,  vecs[i].dig);
      check($sformatf("map%0d_ox", i),  offsetX,        vecs[i].ox);
      check($sformatf("map%0d_oy", i),  offsetY,        vecs[i].oy);
    end

    // Conversion latency; a mid-conversion frame with a new value is ignored.
    pixelX = 11'd100; pixelY = 11'd50;
    value = 14'd9876;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    busy_cnt = 0;
    if (convBusy) busy_cnt++;
    check("lat_busy_k", convBusy, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin startOfFrame = 1'b1; value = 14'd1111; end
      tick();
      startOfFrame = 1'b0;
      if (convBusy) busy_cnt++;
      if (i == 13 || i == 14)
        check($sformatf("lat_busy_k%0d", i), convBusy, (i <= 13));
      if (i == 13 || i == 14)
        check($sformatf("lat_slot0_k%0d", i), current_digit, (i == 14) ? 4'h9 : 4'h1);
    end
    check("lat_busy_cycles", busy_cnt, 14);
    check_strip("lat", 20'h98A76);

    // Frame on the completion edge is ignored.
    value = 14'd55;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    for (int i = 1; i < 14; i++) tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("edge_sof_busy_k14", convBusy, 1'b0);
    tick();
    check("edge_sof_busy_k15", convBusy, 1'b0);

    // Saturation and blanking.
    convert(14'd12000);
    check_strip("sat", 20'h99A99);
    blankLeading = 1'b1;
    check_strip("sat_blank", 20'h99A99);
    convert(14'd7);
    check_strip("blank7", 20'hFFAF7);
    convert(14'd0);
    check_strip("blank0", 20'hFFAF0);
    convert(14'd50);
    check_strip("blank50", 20'hFFA50);
    convert(14'd1005);
    check_strip("blank1005", 20'h10A05);
    blankLeading = 1'b0;
    check_strip("noblank1005", 20'h10A05);

    // Reset mid-conversion.
    value = 14'd4321;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    for (int i = 1; i < 7; i++) tick();
    check("mid_busy", convBusy, 1'b1);
    resetN = 1'b0;
    #2;
    check("mid_rst_dr",    drawingRequest, 1'b0);
    check("mid_rst_digit", current_digit,  4'hF);
    check("mid_rst_ox",    offsetX,        11'd0);
    check("mid_rst_oy",    offsetY,        11'd0);
    check("mid_rst_busy",  convBusy,       1'b0);
    resetN = 1'b1;
    check_strip("mid_zero", 20'h00A00);
    convert(14'd4321);
    check_strip("mid_reconv", 20'h43A21);

    // Negative origin.
    topLeftX = -11'sd20; topLeftY = -11'sd5;
    pix(0, 0);
    check("neg_dr",  drawingRequest, 1'b1);
    check("neg_dig", current_digit,  4'h3);
    check("neg_ox",  offsetX,        11'd4);
    check("neg_oy",  offsetY,        11'd5);
    pix(0, 27);
    check("neg_out_dr",  drawingRequest, 1'b0);
    check("neg_out_dig", current_digit,  4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_strip_display.md
# digit_strip_display

Parametrised successor of the fixed four-slot digit mapper. It owns an on-chip binary-to-BCD converter, a movable strip origin, N digits with an optional ":" separator, leading-zero blanking and a frame-based blink mode. The block sits between game logic (score/countdown binary value, frame strobe) and the digit bitmap ROM, which consumes `offsetX`/`offsetY`/`current_digit`. Its `drawingRequest` goes to the object mux.

## Interface
- `NUM_DIGITS`, default 4: number of decimal digits, range 1..6.
- `VALUE_W`, default 14: width of the binary input value.
- `SEP_AFTER`, default 2: number of digits left of the ":" slot; 0 = no separator.
- `DIGIT_W`, default 16: slot width in pixels; must be a power of 2.
- `DIGIT_H`, default 32: slot height in pixels.
- `BLINK_FRAMES`, default 15: frames per blink half-period; minimum 1.
- `clk`, in, 1: system clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `startOfFrame`, in, 1: one-cycle pulse per VGA frame.
- `pixelX`, `pixelY`, in, 11 each: current VGA pixel.
- `topLeftX`, `topLeftY`, in, signed 11 each: strip origin.
- `value`, in, VALUE_W: binary number to display.
- `blankLeading`, in, 1: blank leading zeros.
- `blinkEn`, in, 1: enable blinking.
- `offsetX`, `offsetY`, out, 11 each: pixel offset inside the current slot.
- `drawingRequest`, out, 1: pixel is inside a visible slot.
- `current_digit`, out, 4: 0..9 = digit, 4'hA = ":", 4'hF = blank.
- `convBusy`, out, 1: BCD conversion in progress.

## Operation
- Slot count: SLOTS = NUM_DIGITS + (SEP_AFTER>0). Slot 0 is leftmost and holds the most significant digit. The ":" slot index is SEP_AFTER.
- Converter FSM has two states, IDLE and SHIFT.
  - IDLE → SHIFT: on `startOfFrame` in IDLE. `value` is latched and saturated to 10^NUM_DIGITS−1 if larger. The BCD accumulator is cleared.
  - SHIFT: performs one double-dabble step per cycle (add 3 to every nibble ≥5, then shift left 1) for VALUE_W cycles. After the last step it returns to IDLE and copies the accumulator to the display-digit registers in the same edge.
  - `startOfFrame` while in SHIFT is ignored; no restart and no queueing.
- Display-digit registers change only on conversion completion. The displayed number is therefore never torn mid-frame.
- Blanking: when `blankLeading`=1, each digit that is 0 and has only zeros to its left shows 4'hF. The least significant digit is never blanked. The separator is never blanked.
- Blink: a frame counter increments on every `startOfFrame`. When it reaches BLINK_FRAMES−1 it wraps to 0 and toggles `phaseOn`.
  - If `blinkEn`=1 and `phaseOn`=0, `drawingRequest` is forced to 0 (offsets still computed).
  - If `blinkEn`=0, the counter keeps running.
- Pixel mapping, computed in 12-bit signed:
  - relX = pixelX − topLeftX, relY = pixelY − topLeftY.
  - inside = relX ≥ 0, relX < SLOTS·DIGIT_W, relY ≥ 0, relY < DIGIT_H.
  - slot = relX >> log2(DIGIT_W); offsetX = relX mod DIGIT_W; offsetY = relY.
- Outside the strip: `drawingRequest`=0, `current_digit`=4'hF, offsets 0.

## Timing
- Reset values:
  - `drawingRequest`=0, `current_digit`=4'hF, `offsetX`=`offsetY`=0, `convBusy`=0.
  - All display digits 0; FSM IDLE; frame counter 0; `phaseOn`=1.
- Pixel path: exactly 1 cycle latency. Outputs at edge n+1 reflect `pixelX`/`pixelY`/`topLeft*` sampled at edge n.
- Conversion: with `startOfFrame` sampled at edge k:
  - `convBusy`=1 from edge k+1 through edge k+VALUE_W.
  - New digits become visible on the pixel path for pixels sampled from edge k+VALUE_W onward.
  - `convBusy`=0 after edge k+VALUE_W.
- `startOfFrame` on the same edge as conversion completion is ignored (the FSM is not yet IDLE). The next frame re-converts.
- Reset asserted mid-conversion: the FSM returns to IDLE immediately and the display digits go to 0. The partial result is discarded.
- `blinkEn`/`blankLeading` take effect on the pixel sampled at the same edge; no frame alignment.

## Test plan
Unless noted, the bench uses defaults with `topLeft`=(100,50).

- **Mapping:** `value`=1234, `blankLeading`=0, one frame converted.
  - Pixel (100,50) → `current_digit`=1, offsets (0,0), `drawingRequest`=1.
  - Pixel (132,60) → 4'hA, offsets (0,10).
  - Pixel (179,81) → 4, offsets (15,31).
  - Pixels (180,50) and (99,50) → `drawingRequest`=0, 4'hF.
- **Conversion latency:** `startOfFrame` at edge k with `value`=9876.
  - `convBusy` is high for exactly 14 cycles.
  - Slot 0 reads 9 from edge k+14; a pixel sampled before that reads the old digit.
  - A second `startOfFrame` at k+5 causes no change.
- **Saturation and blanking:** `value`=12000 → 9,9,:,9,9. `value`=7 with `blankLeading`=1 → F,F,A,F,7. `value`=0 → F,F,A,F,0.
- **Blink:** `BLINK_FRAMES`=2, `blinkEn`=1.
  - `drawingRequest` on a strip pixel is 1 for frames 0–1, 0 for frames 2–3, and 1 again for frame 4.
  - Clearing `blinkEn` during an off phase restores drawing on the next cycle.
- **Reset mid-conversion:** assert `resetN`=0 at k+7.
  - All outputs return to reset values; digits read 0.
  - After release, a new `startOfFrame` converts correctly.
- **Negative origin:** `topLeft`=(−20,−5). Pixel (0,0) → slot 1, offsets (4,5). Pixel (0,27) → `drawingRequest`=0.
